// File: rtl/spi_master_xfer_ctrl_if.sv
// Signal bundle between the APB register block / baud generator and the SPI
// transfer controller. The controller uses the slave view, its environment the master view.
interface spi_master_xfer_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              spe_i;
    logic              mstr_i;
    logic              spiswai_i;
    logic [1:0]        spi_mode_i;
    logic              cpol_i;
    logic              cpha_i;
    logic              lsbfe_i;
    logic              send_data_i;
    logic [DATA_W-1:0] data_mosi_i;
    logic [11:0]       BaudRateDivisor_i;
    logic              mosi_send_sclk_i;
    logic              mosi_send_sclk0_i;
    logic              miso_receive_sclk_i;
    logic              miso_receive_sclk0_i;
    logic              miso_i;
    logic              ss_o;
    logic              mosi_o;
    logic              tip_o;
    logic              receive_data_o;
    logic [DATA_W-1:0] data_miso_o;

    modport slave (
        input  spe_i, mstr_i, spiswai_i, spi_mode_i, cpol_i, cpha_i, lsbfe_i,
               send_data_i, data_mosi_i, BaudRateDivisor_i,
               mosi_send_sclk_i, mosi_send_sclk0_i,
               miso_receive_sclk_i, miso_receive_sclk0_i, miso_i,
        output ss_o, mosi_o, tip_o, receive_data_o, data_miso_o
    );

    modport master (
        output spe_i, mstr_i, spiswai_i, spi_mode_i, cpol_i, cpha_i, lsbfe_i,
               send_data_i, data_mosi_i, BaudRateDivisor_i,
               mosi_send_sclk_i, mosi_send_sclk0_i,
               miso_receive_sclk_i, miso_receive_sclk0_i, miso_i,
        input  ss_o, mosi_o, tip_o, receive_data_o, data_miso_o
    );
endinterface

// File: rtl/spi_master_xfer_ctrl.sv
// Sequences one SPI master byte transfer: drives slave select, shifts MOSI on the
// baud generator's send flags, samples MISO on its receive flags, pulses completion.
module spi_master_xfer_ctrl #(
    parameter int DATA_W = 8,
    parameter int HOLD_W = 16
) (
    input logic                   PCLK,
    input logic                   PRESET_n,
    spi_master_xfer_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam int BIT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, data_miso_q, data_miso_d;
    logic [HOLD_W-1:0] hold_q, hold_d, limit_s;
    logic [IDX_W-1:0]  tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
    logic              mosi_q, mosi_d, ss_q, ss_d, tip_q, tip_d, recv_q, recv_d;
    logic              active_s, sel0_s, send_s, rcv_s;

    // Shift index k -> physical bit position, honouring LSB/MSB-first order.
    function automatic logic [BIT_W-1:0] map_bit(input logic [IDX_W-1:0] k, input logic lsbfe);
        logic [BIT_W-1:0] kb;
        kb = k[BIT_W-1:0];
        if (lsbfe) begin
            map_bit = kb;
        end else begin
            map_bit = BIT_W'(DATA_W - 1) - kb;
        end
    endfunction

    assign active_s = bus.spe_i & bus.mstr_i &
                      ((bus.spi_mode_i == 2'b00) | ((bus.spi_mode_i == 2'b01) & ~bus.spiswai_i));
    assign sel0_s   = bus.cpol_i ^ bus.cpha_i;
    assign send_s   = sel0_s ? bus.mosi_send_sclk0_i   : bus.mosi_send_sclk_i;
    assign rcv_s    = sel0_s ? bus.miso_receive_sclk0_i : bus.miso_receive_sclk_i;
    // Last XFER cycle: ss stays low for exactly DATA_W*divisor clocks.
    assign limit_s  = HOLD_W'(DATA_W) * HOLD_W'(bus.BaudRateDivisor_i) - HOLD_W'(1);

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        hold_d      = hold_q;
        tx_idx_d    = tx_idx_q;
        rx_idx_d    = rx_idx_q;
        mosi_d      = mosi_q;
        data_miso_d = data_miso_q;
        ss_d        = 1'b1;
        tip_d       = 1'b0;
        recv_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.send_data_i && active_s) begin
                    state_d  = XFER;
                    tx_d     = bus.data_mosi_i;
                    rx_d     = '0;
                    hold_d   = '0;
                    rx_idx_d = '0;
                    ss_d     = 1'b0;
                    tip_d    = 1'b1;
                    if (!bus.cpha_i) begin
                        mosi_d   = bus.data_mosi_i[map_bit({IDX_W{1'b0}}, bus.lsbfe_i)];
                        tx_idx_d = IDX_W'(1);
                    end else begin
                        tx_idx_d = '0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                if (!active_s) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                    if (send_s && (tx_idx_q < IDX_W'(DATA_W))) begin
                        mosi_d   = tx_q[map_bit(tx_idx_q, bus.lsbfe_i)];
                        tx_idx_d = tx_idx_q + IDX_W'(1);
                    end else begin
                        tx_idx_d = tx_idx_q;
                    end
                    if (rcv_s && (rx_idx_q < IDX_W'(DATA_W))) begin
                        rx_d[map_bit(rx_idx_q, bus.lsbfe_i)] = bus.miso_i;
                        rx_idx_d = rx_idx_q + IDX_W'(1);
                    end else begin
                        rx_idx_d = rx_idx_q;
                    end
                    if (hold_q == limit_s) begin
                        state_d     = DONE;
                        recv_d      = 1'b1;
                        data_miso_d = rx_d;
                    end else begin
                        ss_d  = 1'b0;
                        tip_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            state_q     <= IDLE;
            tx_q        <= '0;
            rx_q        <= '0;
            hold_q      <= '0;
            tx_idx_q    <= '0;
            rx_idx_q    <= '0;
            mosi_q      <= 1'b0;
            data_miso_q <= '0;
            ss_q        <= 1'b1;
            tip_q       <= 1'b0;
            recv_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            hold_q      <= hold_d;
            tx_idx_q    <= tx_idx_d;
            rx_idx_q    <= rx_idx_d;
            mosi_q      <= mosi_d;
            data_miso_q <= data_miso_d;
            ss_q        <= ss_d;
            tip_q       <= tip_d;
            recv_q      <= recv_d;
        end
    end

    assign bus.ss_o           = ss_q;
    assign bus.mosi_o         = mosi_q;
    assign bus.tip_o          = tip_q;
    assign bus.receive_data_o = recv_q;
    assign bus.data_miso_o    = data_miso_q;
endmodule

// File: tb/tb_spi_master_xfer_ctrl.sv
// Directed bench for spi_master_xfer_ctrl; emulates the baud generator flags
// cycle by cycle and checks pins, framing and the completion pulse.
module tb_spi_master_xfer_ctrl;
    logic PCLK;
    logic PRESET_n;
    int   n_vec;
    int   n_miss;

    spi_master_xfer_ctrl_if bus ();

    spi_master_xfer_ctrl dut (
        .PCLK     (PCLK),
        .PRESET_n (PRESET_n),
        .bus      (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_flags();
        bus.mosi_send_sclk_i     = 1'b0;
        bus.mosi_send_sclk0_i    = 1'b0;
        bus.miso_receive_sclk_i  = 1'b0;
        bus.miso_receive_sclk0_i = 1'b0;
    endtask

    // One transfer. abort_at / resend_at / rst_at = cycle in XFER for that event, -1 = none.
    task automatic xfer(input string tag, input int div, input logic cpol, input logic cpha,
                        input logic lsbfe, input logic [7:0] tx, input logic miso_one,
                        input logic noise, input int abort_at, input int resend_at,
                        input int rst_at, input logic [7:0] exp_seq, input logic [7:0] exp_rx);
        int         lows;
        logic [7:0] seq;
        logic [7:0] prior;
        logic       lead, trail, snd, rcv;
        bus.BaudRateDivisor_i = 12'(div);
        bus.cpol_i  = cpol;
        bus.cpha_i  = cpha;
        bus.lsbfe_i = lsbfe;
        prior = bus.data_miso_o;
        @(negedge PCLK);
        bus.send_data_i = 1'b1;
        bus.data_mosi_i = tx;
        @(negedge PCLK);
        bus.send_data_i = 1'b0;
        bus.data_mosi_i = ~tx;
        lows = 0;
        seq  = 8'h00;
        for (int c = 0; c < 8 * div; c++) begin
            if (bus.ss_o === 1'b0) lows++;
            if (c == 0) check({tag, " tip_in_xfer"}, 32'(bus.tip_o), 32'd1);
            if (c == abort_at) begin
                clear_flags();
                bus.spe_i = 1'b0;
                @(negedge PCLK);
                check({tag, " abort_ss"}, 32'(bus.ss_o), 32'd1);
                check({tag, " abort_tip"}, 32'(bus.tip_o), 32'd0);
                check({tag, " abort_no_pulse"}, 32'(bus.receive_data_o), 32'd0);
                @(negedge PCLK);
                check({tag, " abort_no_pulse2"}, 32'(bus.receive_data_o), 32'd0);
                check({tag, " abort_data_kept"}, 32'(bus.data_miso_o), 32'(prior));
                bus.spe_i = 1'b1;
                return;
            end
            if (c == rst_at) begin
                check({tag, " pre_rst_mosi"}, 32'(bus.mosi_o), 32'd1);
                #2 PRESET_n = 1'b0;
                #1;
                check({tag, " rst_ss"}, 32'(bus.ss_o), 32'd1);
                check({tag, " rst_mosi"}, 32'(bus.mosi_o), 32'd0);
                check({tag, " rst_tip"}, 32'(bus.tip_o), 32'd0);
                check({tag, " rst_pulse"}, 32'(bus.receive_data_o), 32'd0);
                check({tag, " rst_data"}, 32'(bus.data_miso_o), 32'd0);
                clear_flags();
                @(negedge PCLK);
                PRESET_n = 1'b1;
                return;
            end
            lead  = ((c % div) == (div / 2 - 1));
            trail = ((c % div) == (div - 1));
            snd   = cpha ? lead : trail;
            rcv   = cpha ? trail : lead;
            if (cpol ^ cpha) begin
                bus.mosi_send_sclk0_i    = snd;
                bus.miso_receive_sclk0_i = rcv;
                bus.mosi_send_sclk_i     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.miso_receive_sclk_i  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
                bus.mosi_send_sclk_i     = snd;
                bus.miso_receive_sclk_i  = rcv;
                bus.mosi_send_sclk0_i    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.miso_receive_sclk0_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (rcv) begin
                seq = {seq[6:0], bus.mosi_o};
                bus.miso_i = miso_one ? 1'b1 : bus.mosi_o;
            end
            if (c == resend_at) begin
                bus.send_data_i = 1'b1;
                bus.data_mosi_i = 8'h00;
            end else begin
                bus.send_data_i = 1'b0;
            end
            @(negedge PCLK);
        end
        clear_flags();
        bus.send_data_i = 1'b0;
        check({tag, " ss_low_cycles"}, 32'(lows), 32'(8 * div));
        check({tag, " done_ss"}, 32'(bus.ss_o), 32'd1);
        check({tag, " done_tip"}, 32'(bus.tip_o), 32'd0);
        check({tag, " done_pulse"}, 32'(bus.receive_data_o), 32'd1);
        check({tag, " data_miso"}, 32'(bus.data_miso_o), 32'(exp_rx));
        check({tag, " mosi_seq"}, 32'(seq), 32'(exp_seq));
        @(negedge PCLK);
        check({tag, " pulse_end"}, 32'(bus.receive_data_o), 32'd0);
        check({tag, " idle_ss"}, 32'(bus.ss_o), 32'd1);
        check({tag, " idle_tip"}, 32'(bus.tip_o), 32'd0);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        PRESET_n        = 1'b0;
        bus.spe_i       = 1'b1;
        bus.mstr_i      = 1'b1;
        bus.spiswai_i   = 1'b0;
        bus.spi_mode_i  = 2'b00;
        bus.cpol_i      = 1'b0;
        bus.cpha_i      = 1'b0;
        bus.lsbfe_i     = 1'b0;
        bus.send_data_i = 1'b0;
        bus.data_mosi_i = 8'h00;
        bus.BaudRateDivisor_i = 12'd2;
        bus.miso_i      = 1'b0;
        clear_flags();
        #12 PRESET_n = 1'b1;
        @(negedge PCLK);
        check("reset ss", 32'(bus.ss_o), 32'd1);
        check("reset mosi", 32'(bus.mosi_o), 32'd0);
        check("reset tip", 32'(bus.tip_o), 32'd0);
        check("reset pulse", 32'(bus.receive_data_o), 32'd0);
        check("reset data", 32'(bus.data_miso_o), 32'd0);

        // Mode 0, MSB first, loopback
        xfer("t1", 2, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, -1, -1, -1, 8'hA5, 8'hA5);
        // Mode 3, LSB first, MISO held high: wire order 1,0,0,0,0,0,0,0
        xfer("t2", 4, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, -1, -1, -1, 8'h80, 8'hFF);
        // Mode 1 with noise on the unused flag pair
        xfer("t3", 8, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, -1, -1, -1, 8'h3C, 8'h3C);
        // Abort by clearing spe in XFER; data_miso must keep 3C
        xfer("t4", 4, 1'b0, 1'b0, 1'b0, 8'hF0, 1'b1, 1'b0, 5, -1, -1, 8'h00, 8'h00);
        check("t4 data_after_abort", 32'(bus.data_miso_o), 32'h3C);

        // Wait mode with spiswai: start request ignored
        bus.spi_mode_i = 2'b01;
        bus.spiswai_i  = 1'b1;
        @(negedge PCLK);
        bus.send_data_i = 1'b1;
        bus.data_mosi_i = 8'hFF;
        @(negedge PCLK);
        bus.send_data_i = 1'b0;
        check("t5 wait_ss", 32'(bus.ss_o), 32'd1);
        check("t5 wait_tip", 32'(bus.tip_o), 32'd0);
        @(negedge PCLK);
        check("t5 wait_ss2", 32'(bus.ss_o), 32'd1);
        bus.spi_mode_i = 2'b00;
        bus.spiswai_i  = 1'b0;
        // Second start mid-transfer ignored
        xfer("t5b", 2, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, -1, 10, -1, 8'h5A, 8'h5A);

        // Asynchronous reset mid-transfer (bit1 of C3 is on MOSI at cycle 6)
        xfer("t6", 4, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, -1, -1, 6, 8'h00, 8'h00);
        @(negedge PCLK);
        check("t6 post_rst_ss", 32'(bus.ss_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
